binary_mul_pipe_param: RTL and testbench

Parametrised, fully pipelined shift-add binary multiplier. It is the successor to the fixed 12-bit signed pipelined multiplier. It adds generic operand width, per-operation signed/unsigned mode, and valid tracking, so it accepts one new operation every enabled cycle. It sits in the Binary_mul datapath family as the common multiplier core for arithmetic blocks and exhaustive-sweep benches.

---
 rtl/binary_mul_pipe_param.sv | 101 ++++++++++
 tb/tb_binary_mul_pipe_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/binary_mul_pipe_param.sv
// Fully pipelined shift-add multiplier with per-operation signed/unsigned
// mode and valid tracking. One partial product is folded in per stage, so a
// new operation can enter on every enabled cycle. The last adder feeds the
// output register directly, giving WIDTH+1 enabled edges from capture to P.
module binary_mul_pipe_param #(
    parameter int WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    output logic               out_signed,
    output logic [2*WIDTH-1:0] P
);
    localparam int LATENCY = WIDTH + 1;
    // Internal stages 0..STAGES-1; the output register is the final stage.
    localparam int STAGES  = LATENCY - 1;
    localparam int PW      = 2 * WIDTH;

    // Stage k holds: A (extended) pre-shifted left by k, B shifted right by k
    // so bit 0 is always the next multiplier bit, and the sum of PP(0..k-1).
    logic [STAGES-1:0]                 vld_q, vld_d;
    logic [STAGES-1:0]                 sgn_q, sgn_d;
    logic [STAGES-1:0][PW-1:0]         a_q, a_d;
    logic [STAGES-1:0][PW-1:0]         acc_q, acc_d;
    logic [STAGES-1:0][WIDTH-1:0]      b_q, b_d;
    logic                              out_valid_q, out_valid_d;
    logic                              out_signed_q, out_signed_d;
    logic [PW-1:0]                     p_q, p_d;
    logic [PW-1:0]                     pp_last;
    logic [PW-1:0]                     prod;

    // Final partial product: the MSB of B carries negative weight in signed mode.
    always_comb begin
        pp_last = {PW{b_q[STAGES-1][0]}} & a_q[STAGES-1];
        prod    = sgn_q[STAGES-1] ? (acc_q[STAGES-1] - pp_last)
                                  : (acc_q[STAGES-1] + pp_last);
    end

    // Next-state for every stage; en=0 holds the whole pipeline.
    always_comb begin
        vld_d        = vld_q;
        sgn_d        = sgn_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_signed_d = out_signed_q;
        p_d          = p_q;
        if (en) begin
            vld_d[0] = in_valid;
            sgn_d[0] = signed_mode;
            a_d[0]   = signed_mode ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
            b_d[0]   = B;
            acc_d[0] = '0;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                sgn_d[k] = sgn_q[k-1];
                a_d[k]   = a_q[k-1] << 1;
                b_d[k]   = b_q[k-1] >> 1;
                acc_d[k] = acc_q[k-1] + ({PW{b_q[k-1][0]}} & a_q[k-1]);
            end
            out_valid_d = vld_q[STAGES-1];
            if (vld_q[STAGES-1]) begin
                p_d          = prod;
                out_signed_d = sgn_q[STAGES-1];
            end
        end
    end

    // Control and output registers: reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q        <= '0;
            out_valid_q  <= 1'b0;
            out_signed_q <= 1'b0;
            p_q          <= '0;
        end else begin
            vld_q        <= vld_d;
            out_valid_q  <= out_valid_d;
            out_signed_q <= out_signed_d;
            p_q          <= p_d;
        end
    end

    // Datapath registers: contents are don't-care whenever the valid bit is 0.
    always_ff @(posedge clk) begin
        sgn_q <= sgn_d;
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign out_valid  = out_valid_q;
    assign out_signed = out_signed_q;
    assign P          = p_q;
endmodule

// File: tb/tb_binary_mul_pipe_param.sv
// Directed bench for binary_mul_pipe_param: a WIDTH=12 instance driven from a
// vector table and hand-written stall/reset sequences, plus a WIDTH=4 instance
// swept over every operand pair in both modes.
module tb_binary_mul_pipe_param;
    localparam int LAT  = 13;
    localparam int LAT4 = 5;

    logic        clk = 1'b0;
    logic        rst, en, in_valid, sm;
    logic [11:0] a, b;
    logic        out_valid, out_signed;
    logic [23:0] p;

    logic        rst4, en4, in_valid4, sm4;
    logic [3:0]  a4, b4;
    logic        out_valid4, out_signed4;
    logic [7:0]  p4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    binary_mul_pipe_param #(.WIDTH(12)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .signed_mode(sm),
        .A(a), .B(b), .out_valid(out_valid), .out_signed(out_signed), .P(p)
    );

    binary_mul_pipe_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .in_valid(in_valid4), .signed_mode(sm4),
        .A(a4), .B(b4), .out_valid(out_valid4), .out_signed(out_signed4), .P(p4)
    );

    typedef struct {
        logic        sm;
        logic [11:0] a;
        logic [11:0] b;
        logic [23:0] p;
    } vec_t;

    vec_t tbl[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref4(input bit s, input logic [3:0] x, input logic [3:0] y);
        int xi, yi;
        logic [31:0] r;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        r  = xi * yi;
        return r[7:0];
    endfunction

    // Capture one op, then require silence for LAT-1 edges and the result on edge LAT.
    task automatic single_op(input string nm, input logic s, input logic [11:0] x,
                             input logic [11:0] y, input logic [23:0] exp);
        int early;
        early = 0;
        in_valid = 1'b1; sm = s; a = x; b = y;
        step();
        in_valid = 1'b0;
        if (out_valid) early++;
        for (int i = 1; i < LAT - 1; i++) begin
            step();
            if (out_valid) early++;
        end
        chk({nm, " early_valid"}, early, 0);
        step();
        chk({nm, " valid"}, out_valid, 1'b1);
        chk({nm, " P"}, p, exp);
        chk({nm, " out_signed"}, out_signed, s);
    endtask

    initial begin
        int stray;
        int early;
        logic [23:0] frozen_p;

        tbl[0]  = '{1'b0, 12'hFFF, 12'hFFF, 24'hFFE001};
        tbl[1]  = '{1'b0, 12'h000, 12'hFFF, 24'h000000};
        tbl[2]  = '{1'b1, 12'hFFF, 12'h7FF, 24'hFFF801};
        tbl[3]  = '{1'b1, 12'h800, 12'h800, 24'h400000};
        tbl[4]  = '{1'b1, 12'h7FF, 12'h7FF, 24'h3FF001};
        tbl[5]  = '{1'b1, 12'h800, 12'h7FF, 24'hC00800};
        tbl[6]  = '{1'b0, 12'h800, 12'h800, 24'h400000};
        tbl[7]  = '{1'b1, 12'h000, 12'hFFB, 24'h000000};
        tbl[8]  = '{1'b0, 12'd123, 12'd45,  24'h00159F};
        tbl[9]  = '{1'b1, 12'hFF9, 12'h00D, 24'hFFFFA5};
        tbl[10] = '{1'b1, 12'hFFF, 12'h002, 24'hFFFFFE};
        tbl[11] = '{1'b0, 12'hFFF, 12'h002, 24'h001FFE};
        tbl[12] = '{1'b1, 12'hFFF, 12'h002, 24'hFFFFFE};
        tbl[13] = '{1'b0, 12'hFFF, 12'h002, 24'h001FFE};
        tbl[14] = '{1'b1, 12'hFFF, 12'h002, 24'hFFFFFE};
        tbl[15] = '{1'b0, 12'hFFF, 12'h002, 24'h001FFE};

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; sm = 1'b0; a = '0; b = '0;
        rst4 = 1'b1; en4 = 1'b1; in_valid4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        step();
        step();
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset P", p, 24'h0);
        chk("reset out_signed", out_signed, 1'b0);
        chk("reset4 out_valid", out_valid4, 1'b0);
        rst = 1'b0; rst4 = 1'b0;

        // Signed corner: (-2048)*(-2048), then the next edge is a bubble.
        single_op("min_x_min", 1'b1, 12'h800, 12'h800, 24'h400000);
        step();
        chk("min_x_min bubble valid", out_valid, 1'b0);
        chk("min_x_min bubble P hold", p, 24'h400000);
        chk("min_x_min bubble sign hold", out_signed, 1'b1);

        // Table stream: one op per cycle, results must come out in order.
        early = 0;
        for (int t = 0; t < 16 + LAT - 1; t++) begin
            if (t < 16) begin
                in_valid = 1'b1; sm = tbl[t].sm; a = tbl[t].a; b = tbl[t].b;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (t >= LAT - 1) begin
                chk($sformatf("tbl[%0d] valid", t - LAT + 1), out_valid, 1'b1);
                chk($sformatf("tbl[%0d] P", t - LAT + 1), p, tbl[t - LAT + 1].p);
                chk($sformatf("tbl[%0d] sign", t - LAT + 1), out_signed, tbl[t - LAT + 1].sm);
            end else if (out_valid) begin
                early++;
            end
        end
        chk("stream early_valid", early, 0);
        in_valid = 1'b0;
        step();
        chk("stream tail valid", out_valid, 1'b0);
        frozen_p = tbl[15].p;

        // Stall mid-flight: 6 enabled edges, 5 stalled, then 7 more enabled.
        in_valid = 1'b1; sm = 1'b0; a = 12'd100; b = 12'd200;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("pre-stall valid", out_valid, 1'b0);
        en = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; sm = i[0]; a = 12'd7; b = 12'd9;
            step();
            if (out_valid || p !== frozen_p) stray++;
        end
        chk("stall frozen", stray, 0);
        en = 1'b1; in_valid = 1'b0;
        early = 0;
        repeat (6) begin
            step();
            if (out_valid) early++;
        end
        chk("stall early_valid", early, 0);
        step();
        chk("stall result valid", out_valid, 1'b1);
        chk("stall result P", p, 24'h004E20);
        chk("stall result sign", out_signed, 1'b0);
        stray = 0;
        repeat (LAT + 2) begin
            step();
            if (out_valid) stray++;
        end
        chk("stall in_valid ignored", stray, 0);

        // Reset with six ops in flight: nothing may emerge afterwards.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; sm = 1'b0; a = 12'(i + 3); b = 12'd3;
            step();
        end
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst valid", out_valid, 1'b0);
        chk("midrst P", p, 24'h0);
        chk("midrst sign", out_signed, 1'b0);
        stray = 0;
        repeat (LAT + 2) begin
            step();
            if (out_valid || p !== 24'h0) stray++;
        end
        chk("midrst no stale", stray, 0);
        single_op("post_rst", 1'b1, 12'hFFD, 12'h005, 24'hFFFFF1);

        // WIDTH=4 exhaustive sweep: 512 ops streamed back-to-back.
        early = 0;
        for (int t = 0; t < 512 + LAT4 - 1; t++) begin
            if (t < 512) begin
                in_valid4 = 1'b1; sm4 = t[8]; a4 = t[7:4]; b4 = t[3:0];
            end else begin
                in_valid4 = 1'b0;
            end
            step();
            if (t >= LAT4 - 1) begin
                int j;
                logic [8:0] jv;
                j  = t - LAT4 + 1;
                jv = j[8:0];
                chk($sformatf("w4 %0d valid", j), out_valid4, 1'b1);
                chk($sformatf("w4 s=%0d a=%0h b=%0h P", jv[8], jv[7:4], jv[3:0]),
                    p4, ref4(jv[8], jv[7:4], jv[3:0]));
                chk($sformatf("w4 %0d sign", j), out_signed4, jv[8]);
            end else if (out_valid4) begin
                early++;
            end
        end
        chk("w4 early_valid", early, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
